// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bundle: redirect from next-PC adder, imem req/ack port, and valid/ready decode port.
// master = fetch_pc_unit, slave = surrounding pipeline/memory.
interface fetch_pc_unit_if;
  logic [31:0] next_pc;
  logic        redirect;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  modport master (
    input  next_pc, redirect, imem_ack, imem_rdata, if_ready,
    output pc, imem_req, imem_addr, if_valid, if_pc, if_instr
  );

  modport slave (
    output next_pc, redirect, imem_ack, imem_rdata, if_ready,
    input  pc, imem_req, imem_addr, if_valid, if_pc, if_instr
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// PC register + single-outstanding imem fetch sequencer feeding a 2-entry {pc,instr} FIFO.
// Ack in T -> if_valid in T+1; fetch stalls when FIFO would be full; redirect flushes and drops in-flight read.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          INCR     = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_pc_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

  state_t      state;
  logic [1:0]  count;
  logic [31:0] e0_pc, e0_instr, e1_pc, e1_instr;
  logic [31:0] pc_q, req_addr;
  logic        req_q;

  logic        push, pop, free, issue;
  logic [1:0]  count_next, wslot;

  always_comb begin
    pop        = bus.if_valid & bus.if_ready & ~bus.redirect;
    push       = bus.imem_ack & (state == BUSY) & ~bus.redirect;
    count_next = count + {1'b0, push} - {1'b0, pop};
    wslot      = count - {1'b0, pop};
    // The outstanding read retires at this edge if it is acked, so a new one may go out.
    free       = (state == IDLE) | bus.imem_ack;
    issue      = free & ~bus.redirect & (count_next < 2'd2);
  end

  assign bus.pc        = pc_q;
  assign bus.imem_req  = req_q;
  assign bus.imem_addr = req_addr;
  assign bus.if_valid  = (count != 2'd0);
  assign bus.if_pc     = e0_pc;
  assign bus.if_instr  = e0_instr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      req_addr <= 32'h0;
      count    <= 2'd0;
      e0_pc    <= 32'h0;
      e0_instr <= 32'h0;
      e1_pc    <= 32'h0;
      e1_instr <= 32'h0;
    end else if (bus.redirect) begin
      pc_q  <= bus.next_pc;
      count <= 2'd0;
      // An unacked read cannot be cancelled on the bus; keep it up and discard its data later.
      if (state != IDLE && !bus.imem_ack) begin
        state <= DROP;
      end else begin
        state <= IDLE;
        req_q <= 1'b0;
      end
    end else begin
      count <= count_next;
      if (pop) begin
        e0_pc    <= e1_pc;
        e0_instr <= e1_instr;
      end
      // Later assignment wins: a push into slot 0 overrides the shift above.
      if (push) begin
        if (wslot == 2'd0) begin
          e0_pc    <= req_addr;
          e0_instr <= bus.imem_rdata;
        end else begin
          e1_pc    <= req_addr;
          e1_instr <= bus.imem_rdata;
        end
      end
      if (issue) begin
        req_q    <= 1'b1;
        req_addr <= pc_q;
        pc_q     <= pc_q + 32'(INCR);
        state    <= BUSY;
      end else if (state != IDLE && bus.imem_ack) begin
        req_q <= 1'b0;
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scenario bench for fetch_pc_unit: bench-side memory responder with a scoreboard of expected {pc,instr}.
module tb_fetch_pc_unit;

  logic clk = 1'b0;
  logic rst;
  fetch_pc_unit_if bus();

  fetch_pc_unit #(.RESET_PC(32'h0), .INCR(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];
  bit          drop;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0] ^ 16'h3c5a, ~a[31:16]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of inputs and updates the expected-word queue from the bench's own view.
  task automatic drive(input logic ack, input logic rdy, input logic redir, input logic [31:0] tgt);
    bus.imem_ack   = ack;
    bus.if_ready   = rdy;
    bus.redirect   = redir;
    bus.next_pc    = tgt;
    bus.imem_rdata = ack ? word(bus.imem_addr) : $urandom;
    if (redir) begin
      exp_q.delete();
      drop = bus.imem_req && !ack;
    end else if (ack && bus.imem_req) begin
      if (!drop) exp_q.push_back({bus.imem_addr, word(bus.imem_addr)});
      drop = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.imem_ack   = 1'b0;
    bus.if_ready   = 1'b0;
    bus.redirect   = 1'b0;
    bus.next_pc    = 32'h0;
    bus.imem_rdata = 32'h0;
    exp_q.delete();
    drop = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Zero-wait memory, decode always ready; checks addresses and popped words against the scoreboard.
  task automatic run_stream(input int n, input logic [31:0] first_addr);
    logic [31:0] ea;
    logic [63:0] want;
    ea = first_addr;
    for (int i = 0; i < n; i++) begin
      total++;
      if (bus.if_valid !== (exp_q.size() != 0)) begin
        bad++;
        $display("FAIL stream_valid: got %b want %b", bus.if_valid, exp_q.size() != 0);
      end
      if (bus.imem_req) begin
        total++;
        if (bus.imem_addr !== ea) begin
          bad++;
          $display("FAIL stream_addr: got %h want %h", bus.imem_addr, ea);
        end
        ea = ea + 32'd4;
      end
      if (bus.if_valid) begin
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        total++;
        if ({bus.if_pc, bus.if_instr} !== want) begin
          bad++;
          $display("FAIL stream_word: got %h want %h", {bus.if_pc, bus.if_instr}, want);
        end
      end
      drive(bus.imem_req, 1'b1, 1'b0, 32'h0);
      tick();
    end
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.imem_ack   = 1'b0;
    bus.if_ready   = 1'b0;
    bus.redirect   = 1'b0;
    bus.next_pc    = 32'h0;
    bus.imem_rdata = 32'h0;
    #2;
    total++;
    if (bus.pc !== 32'h0 || bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 ||
        bus.if_valid !== 1'b0 || bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: pc=%h req=%b addr=%h vld=%b ifpc=%h instr=%h want all zero",
               bus.pc, bus.imem_req, bus.imem_addr, bus.if_valid, bus.if_pc, bus.if_instr);
    end
    tick();
    tick();
    total++;
    if (bus.imem_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold_req: got %b want 0", bus.imem_req);
    end
    rst = 1'b0;
    tick();
    total++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.pc !== 32'h4) begin
      bad++;
      $display("FAIL reset_first_issue: req=%b addr=%h pc=%h want 1 0 4", bus.imem_req, bus.imem_addr, bus.pc);
    end
  endtask

  task automatic test_stream();
    logic [63:0] want;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * i)) begin
        bad++;
        $display("FAIL seq_addr: req=%b addr=%h want 1 %h", bus.imem_req, bus.imem_addr, 32'(4 * i));
      end
      total++;
      if (bus.if_valid !== (i > 0)) begin
        bad++;
        $display("FAIL seq_valid: got %b want %b", bus.if_valid, i > 0);
      end
      if (bus.if_valid) begin
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        total++;
        if ({bus.if_pc, bus.if_instr} !== want) begin
          bad++;
          $display("FAIL seq_word: got %h want %h", {bus.if_pc, bus.if_instr}, want);
        end
      end
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] want;
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    total++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
      bad++;
      $display("FAIL bp_second_req: req=%b addr=%h want 1 4", bus.imem_req, bus.imem_addr);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    total++;
    if (bus.imem_req !== 1'b0 || bus.pc !== 32'h8 || bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin
      bad++;
      $display("FAIL bp_full: req=%b pc=%h vld=%b ifpc=%h want 0 8 1 0",
               bus.imem_req, bus.pc, bus.if_valid, bus.if_pc);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    total++;
    if (bus.imem_req !== 1'b0 || exp_q.size() != 2) begin
      bad++;
      $display("FAIL bp_stall: req=%b queued=%0d want 0 2", bus.imem_req, exp_q.size());
    end
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    total++;
    if ({bus.if_pc, bus.if_instr} !== want) begin
      bad++;
      $display("FAIL bp_head: got %h want %h", {bus.if_pc, bus.if_instr}, want);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    total++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin
      bad++;
      $display("FAIL bp_resume: req=%b addr=%h want 1 8", bus.imem_req, bus.imem_addr);
    end
    run_stream(6, 32'h8);
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    run_stream(2, 32'h0);
    total++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin
      bad++;
      $display("FAIL rdi_pre: req=%b addr=%h want 1 8", bus.imem_req, bus.imem_addr);
    end
    drive(1'b0, 1'b1, 1'b1, 32'h100);
    tick();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || bus.pc !== 32'h100) begin
        bad++;
        $display("FAIL rdi_drop_hold: vld=%b req=%b addr=%h pc=%h want 0 1 8 100",
                 bus.if_valid, bus.imem_req, bus.imem_addr, bus.pc);
      end
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    total++;
    if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
      bad++;
      $display("FAIL rdi_after_drop: vld=%b req=%b addr=%h want 0 1 100", bus.if_valid, bus.imem_req, bus.imem_addr);
    end
    run_stream(4, 32'h100);
  endtask

  task automatic test_redirect_ack();
    do_reset();
    run_stream(1, 32'h0);
    total++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
      bad++;
      $display("FAIL rda_pre: req=%b addr=%h want 1 4", bus.imem_req, bus.imem_addr);
    end
    drive(1'b1, 1'b1, 1'b1, 32'h100);
    tick();
    total++;
    if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0 || bus.pc !== 32'h100) begin
      bad++;
      $display("FAIL rda_idle: req=%b vld=%b pc=%h want 0 0 100", bus.imem_req, bus.if_valid, bus.pc);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    total++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
      bad++;
      $display("FAIL rda_restart: req=%b addr=%h want 1 100", bus.imem_req, bus.imem_addr);
    end
    run_stream(3, 32'h100);
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    tick();
    total++;
    if (bus.imem_req !== 1'b0 || bus.pc !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_load: req=%b pc=%h want 0 fffffffc", bus.imem_req, bus.pc);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    total++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC || bus.pc !== 32'h0) begin
      bad++;
      $display("FAIL wrap_issue: req=%b addr=%h pc=%h want 1 fffffffc 0", bus.imem_req, bus.imem_addr, bus.pc);
    end
    run_stream(3, 32'hFFFF_FFFC);
  endtask

  task automatic test_reset_midbusy();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0 || bus.pc !== 32'h0 ||
        bus.imem_addr !== 32'h0 || bus.if_pc !== 32'h0) begin
      bad++;
      $display("FAIL midreset_clear: req=%b vld=%b pc=%h addr=%h ifpc=%h want all zero",
               bus.imem_req, bus.if_valid, bus.pc, bus.imem_addr, bus.if_pc);
    end
    exp_q.delete();
    drop = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.if_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_restart: req=%b addr=%h vld=%b want 1 0 0", bus.imem_req, bus.imem_addr, bus.if_valid);
    end
    run_stream(3, 32'h0);
  endtask

  initial begin
    drop = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_ack();
    test_wrap();
    test_reset_midbusy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
